// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; optional retired-instruction counter under MCTRL_INSTRET_EN.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; outputs decoded from state, pcwrite/irwrite also from zero/mem_ready.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD and MEMWRITE one cycle per low cycle.
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal
`ifdef MCTRL_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
    } state_t;

    state_t     state, state_next;
    logic       ir_en, pc_en, rw_en, mw_en, ill;
    logic       use_funct;
    logic [2:0] alu_fixed, alu_funct;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        adrsrc     = 1'b0;
        alu_fixed  = 3'b000;
        use_funct  = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        rw_en      = 1'b0;
        mw_en      = 1'b0;
        ill        = 1'b0;
        case (state)
            FETCH: begin
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                ir_en      = mem_ready;
                pc_en      = mem_ready;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
                    default: begin
                        ill        = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc     = 1'b1;
                state_next = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                rw_en     = 1'b1;
            end
            MEMWRITE: begin
                adrsrc     = 1'b1;
                mw_en      = 1'b1;
                state_next = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alusrca    = 2'b10;
                use_funct  = 1'b1;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                use_funct  = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: rw_en = 1'b1;
            JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                pc_en      = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                alusrca   = 2'b10;
                alu_fixed = 3'b001;
                pc_en     = zero;
            end
            default: state_next = FETCH;
        endcase
    end

    // op[5] separates R-type sub from I-type addi, which has no subtract form
    always_comb begin
        case (funct3)
            3'b000:  alu_funct = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    assign alucontrol = use_funct ? alu_funct : alu_fixed;

    // Reset gates the enables so a mid-instruction reset cannot write anything
    assign irwrite  = ir_en & ~reset;
    assign pcwrite  = pc_en & ~reset;
    assign regwrite = rw_en & ~reset;
    assign memwrite = mw_en & ~reset;
    assign illegal  = ill   & ~reset;

`ifdef MCTRL_INSTRET_EN
    logic retire;
    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + INSTRET_W'(1);
    end
`else
    logic unused_instret_w;
    assign unused_instret_w = (INSTRET_W != 0);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control-word checks against hand-derived state signatures.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
    logic [2:0] alucontrol;
`ifdef MCTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .immsrc(immsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .resultsrc(resultsrc), .adrsrc(adrsrc),
        .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal)
`ifdef MCTRL_INSTRET_EN
        , .instret(instret)
`endif
    );

    // {adrsrc, alusrca, alusrcb, resultsrc, alucontrol, irwrite, pcwrite, regwrite, memwrite, illegal}
    wire [14:0] sig = {adrsrc, alusrca, alusrcb, resultsrc, alucontrol,
                       irwrite, pcwrite, regwrite, memwrite, illegal};

    localparam logic [14:0] S_FETCH    = {1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 5'b11000};
    localparam logic [14:0] S_FETCH_W  = {1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 5'b00000};
    localparam logic [14:0] S_DECODE   = {1'b0, 2'b01, 2'b01, 2'b00, 3'b000, 5'b00000};
    localparam logic [14:0] S_DEC_ILL  = {1'b0, 2'b01, 2'b01, 2'b00, 3'b000, 5'b00001};
    localparam logic [14:0] S_MEMADR   = {1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 5'b00000};
    localparam logic [14:0] S_MEMREAD  = {1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000};
    localparam logic [14:0] S_MEMWB    = {1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 5'b00100};
    localparam logic [14:0] S_MEMWRITE = {1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00010};
    localparam logic [14:0] S_MEMW_RST = {1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000};
    localparam logic [14:0] S_ALUWB    = {1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00100};
    localparam logic [14:0] S_JAL      = {1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 5'b01000};
    localparam logic [14:0] S_BEQ_T    = {1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 5'b01000};
    localparam logic [14:0] S_BEQ_NT   = {1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 5'b00000};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic run_instr(input logic [6:0] o, input int cycles);
        op = o;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; op = OP_LW;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sig !== S_FETCH_W) $display("FAIL reset_hold: sig=%h expected %h", sig, S_FETCH_W);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if (sig !== S_FETCH) $display("FAIL reset_release: sig=%h expected %h", sig, S_FETCH);
        else passed++;
`ifdef MCTRL_INSTRET_EN
        checks++;
        if (instret !== 32'd0) $display("FAIL reset_instret: instret=%0d expected 0", instret);
        else passed++;
`endif
        @(posedge clk); #1;
        // FETCH with mem_ready=1 moved on; bring the FSM back to FETCH with a reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [14:0] exp [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_FETCH};
        op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (sig !== exp[i]) $display("FAIL lw_cycle%0d: sig=%h expected %h", i, sig, exp[i]);
            else passed++;
            if (i < 5) begin @(posedge clk); #1; end
        end
        checks++;
        if (immsrc !== 2'b00) $display("FAIL lw_immsrc: immsrc=%b expected 00", immsrc);
        else passed++;
    endtask

    task automatic test_sw_stall();
        logic        mr  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [14:0] exp [9] = '{S_FETCH_W, S_FETCH, S_DECODE, S_MEMADR,
                                 S_MEMWRITE, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE, S_FETCH};
        op = OP_SW; funct3 = 3'b010;
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (sig !== exp[i]) $display("FAIL sw_cycle%0d: sig=%h expected %h", i, sig, exp[i]);
            else passed++;
            if (i == 4) begin
                checks++;
                if (immsrc !== 2'b01) $display("FAIL sw_immsrc: immsrc=%b expected 01", immsrc);
                else passed++;
            end
            if (i < 8) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] t_op  [7] = '{OP_R, OP_R, OP_I, OP_R, OP_I, OP_R, OP_I};
        logic [2:0] t_f3  [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
        logic       t_f7  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] t_alu [7] = '{3'b001, 3'b000, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
        logic [14:0] exp [4];
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            op = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k];
            exp[0] = S_FETCH;
            exp[1] = S_DECODE;
            exp[2] = {1'b0, 2'b10, (t_op[k] == OP_R) ? 2'b00 : 2'b01, 2'b00, t_alu[k], 5'b00000};
            exp[3] = S_ALUWB;
            for (int j = 0; j < 4; j++) begin
                #1;
                checks++;
                if (sig !== exp[j])
                    $display("FAIL alu%0d_cycle%0d: sig=%h expected %h", k, j, sig, exp[j]);
                else passed++;
                @(posedge clk); #1;
            end
        end
        funct7b5 = 1'b0;
        #1;
        checks++;
        if (sig !== S_FETCH) $display("FAIL alu_return: sig=%h expected %h", sig, S_FETCH);
        else passed++;
    endtask

    task automatic test_beq();
        logic [14:0] exp [4];
        op = OP_BEQ; funct3 = 3'b000; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            exp = '{S_FETCH, S_DECODE, (z == 1) ? S_BEQ_T : S_BEQ_NT, S_FETCH};
            for (int j = 0; j < 4; j++) begin
                #1;
                checks++;
                if (sig !== exp[j])
                    $display("FAIL beq_z%0d_cycle%0d: sig=%h expected %h", z, j, sig, exp[j]);
                else passed++;
                if (j < 3) begin @(posedge clk); #1; end
            end
        end
        checks++;
        if (immsrc !== 2'b10) $display("FAIL beq_immsrc: immsrc=%b expected 10", immsrc);
        else passed++;
        zero = 1'b0;
    endtask

    task automatic test_jal_illegal();
        logic [14:0] exp_j [5] = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH};
        logic [14:0] exp_i [3] = '{S_FETCH, S_DEC_ILL, S_FETCH};
        op = OP_JAL; mem_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++;
            if (sig !== exp_j[j]) $display("FAIL jal_cycle%0d: sig=%h expected %h", j, sig, exp_j[j]);
            else passed++;
            if (j < 4) begin @(posedge clk); #1; end
        end
        checks++;
        if (immsrc !== 2'b11) $display("FAIL jal_immsrc: immsrc=%b expected 11", immsrc);
        else passed++;
        op = OP_BAD;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (sig !== exp_i[j]) $display("FAIL illegal_cycle%0d: sig=%h expected %h", j, sig, exp_i[j]);
            else passed++;
            if (j < 2) begin @(posedge clk); #1; end
        end
        checks++;
        if (immsrc !== 2'b00) $display("FAIL illegal_immsrc: immsrc=%b expected 00", immsrc);
        else passed++;
    endtask

    task automatic test_reset_midway();
        mem_ready = 1'b1;
        run_instr(OP_LW, 3);
        reset = 1'b1;
        #1;
        checks++;
        if (sig !== S_MEMREAD) $display("FAIL rst_memread: sig=%h expected %h", sig, S_MEMREAD);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (sig !== S_FETCH) $display("FAIL rst_memread_next: sig=%h expected %h", sig, S_FETCH);
        else passed++;
        run_instr(OP_SW, 3);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (sig !== S_MEMW_RST) $display("FAIL rst_memwrite: sig=%h expected %h", sig, S_MEMW_RST);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (sig !== S_FETCH) $display("FAIL rst_memwrite_next: sig=%h expected %h", sig, S_FETCH);
        else passed++;
`ifdef MCTRL_INSTRET_EN
        checks++;
        if (instret !== 32'd0) $display("FAIL instret_cleared: instret=%0d expected 0", instret);
        else passed++;
        zero = 1'b0;
        run_instr(OP_LW, 5);
        funct3 = 3'b000;
        run_instr(OP_I, 4);
        run_instr(OP_BEQ, 3);
        checks++;
        if (instret !== 32'd3) $display("FAIL instret_three: instret=%0d expected 3", instret);
        else passed++;
        run_instr(OP_BAD, 2);
        checks++;
        if (instret !== 32'd3) $display("FAIL instret_illegal: instret=%0d expected 3", instret);
        else passed++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_alu_decode();
        test_beq();
        test_jal_illegal();
        test_reset_midway();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, register file and PC, and selects the immediate format (immsrc) for the immediate-extend unit.
- Supports lw, sw, R-type ALU ops, I-type ALU ops, beq and jal.
- Sits beside the datapath and reads op, funct3 and funct7b5 from the instruction register.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter (used only when MCTRL_INSTRET_EN is defined)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous reset, active-high
op  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
immsrc  out  2  extend format: 00 I, 01 S, 10 B, 11 J
alusrca  out  2  00 PC, 01 oldPC, 10 rs1 data
alusrcb  out  2  00 rs2 data, 01 immext, 10 constant 4
resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
adrsrc  out  1  0 PC, 1 result
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
irwrite  out  1  instruction register load enable
pcwrite  out  1  PC load enable
regwrite  out  1  register file write enable
memwrite  out  1  memory write enable
illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high: when reset=1 at a rising edge, state <= FETCH.
  - While reset=1, irwrite, pcwrite, regwrite, memwrite and illegal are forced to 0 combinationally. This also applies when reset arrives mid-instruction.
- Output timing: outputs are Moore, decoded from state. Exceptions: pcwrite depends on zero and mem_ready; irwrite depends on mem_ready. Unlisted outputs are 0.
- immsrc decode (from op, valid in every state):
  - 0000011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other op → 00
- FETCH:
  - adrsrc=0, alusrca=00, alusrcb=10, ALU add, resultsrc=10.
  - irwrite=pcwrite=mem_ready.
  - Next state: DECODE if mem_ready, else FETCH.
- DECODE:
  - alusrca=01, alusrcb=01, add (computes branch target).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - otherwise illegal=1 and next state FETCH
- MEMADR:
  - alusrca=10, alusrcb=01, add.
  - Next state: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD:
  - adrsrc=1, resultsrc=00.
  - Holds until mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1. Next state FETCH.
- MEMWRITE:
  - adrsrc=1, resultsrc=00, memwrite=1.
  - Holds with memwrite=1 until mem_ready, then FETCH.
- EXECUTER: alusrca=10, alusrcb=00, ALU decoded from funct. Next state ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, ALU decoded from funct. Next state ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next state FETCH.
- JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1. Next state ALUWB.
- BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00, pcwrite=zero. Next state FETCH.
- Funct-decoded ALU:
  - funct3 000 → sub if (op[5] & funct7b5), else add
  - funct3 010 → slt
  - funct3 110 → or
  - funct3 111 → and
  - any other funct3 → add
- Latency with mem_ready held 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- State register is never left in an unencoded value; unused encodings go to FETCH.

Optional Feature:
- Macro: MCTRL_INSTRET_EN.
- When defined:
  - Adds output port instret [INSTRET_W-1:0], cleared to 0 by reset.
  - Increments by 1 on each edge where the state leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ to FETCH.
  - Wraps from all-ones to 0.
  - Illegal opcodes are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then lw (op=0000011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 only in cycle 5 with resultsrc=01; immsrc=00.
2. sw with mem_ready=0 for 3 cycles in MEMWRITE → memwrite=1 held for 4 cycles, then FETCH. immsrc=01; regwrite never 1.
3. R-type sub (funct3=000, funct7b5=1) → alucontrol=001 in EXECUTER. Same with op=0010011 and funct7b5=1 → alucontrol=000.
4. beq with zero=1 → pcwrite=1 in BEQ, immsrc=10. With zero=0 → pcwrite=0; 3 cycles in both cases.
5. jal → pcwrite=1 in JAL, immsrc=11, then ALUWB regwrite=1. Then op=1111111 → illegal=1 for one cycle in DECODE, next state FETCH.
6. reset=1 asserted during MEMREAD → all write enables 0 that cycle, FETCH on the next cycle. With MCTRL_INSTRET_EN defined, instret=0 after reset and equals 3 after lw, addi, beq.
